// File: rtl/recv_img_pkg.sv
// Shared types and default sizing for the image receiver and its idle timer.
package recv_img_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RECEIVING,
    FULL
  } state_t;

  localparam int DEF_BIT_DEPTH = 8;
  localparam int DEF_WIDTH     = 64;
  localparam int DEF_HEIGHT    = 64;
  localparam int DEF_TIMEOUT   = 1000000;
  localparam int PIX_COUNT     = DEF_WIDTH * DEF_HEIGHT;
  localparam int TIMER_W       = $clog2(DEF_TIMEOUT);

endpackage

// File: rtl/recv_img_idle.sv
// Idle timer: counts enabled clocks and pulses tc_o on the terminal count.
module idle_timer #(
  parameter int TIMEOUT_CYCLES = recv_img_pkg::DEF_TIMEOUT
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic enable_i,
  output logic tc_o
);

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] count_q, count_d;

  // A clear in the terminal cycle suppresses the pulse, so a late byte still wins.
  assign tc_o = enable_i && !clear_i && (count_q == LAST);

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i) begin
      count_d = (count_q == LAST) ? '0 : count_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/recv_img.sv
// Writes a UART byte stream raster-order into a frame BRAM, flagging timeouts and overruns.
module recv_img
  import recv_img_pkg::*;
#(
  parameter int BIT_DEPTH      = DEF_BIT_DEPTH,
  parameter int WIDTH          = DEF_WIDTH,
  parameter int HEIGHT         = DEF_HEIGHT,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT
) (
  input  logic                              clk_in,
  input  logic                              rst_in,
  input  logic [BIT_DEPTH-1:0]              data_in,
  input  logic                              valid_in,
  input  logic                              rearm_in,
  output logic [$clog2(WIDTH*HEIGHT)-1:0]   addr_out,
  output logic [BIT_DEPTH-1:0]              data_out,
  output logic                              we_out,
  output logic [$clog2(WIDTH)-1:0]          x_out,
  output logic [$clog2(HEIGHT)-1:0]         y_out,
  output logic                              busy_out,
  output logic                              frame_done_out,
  output logic                              image_ready_out,
  output logic                              timeout_out,
  output logic                              overrun_out
);

  localparam int XW = $clog2(WIDTH);
  localparam int YW = $clog2(HEIGHT);
  localparam int AW = $clog2(WIDTH * HEIGHT);

  state_t               state_q, state_d;
  logic [XW-1:0]        xCnt_q, xCnt_d, xOut_q, xOut_d;
  logic [YW-1:0]        yCnt_q, yCnt_d, yOut_q, yOut_d;
  logic [AW-1:0]        addr_q, addr_d;
  logic [BIT_DEPTH-1:0] data_q, data_d;
  logic                 we_q, we_d, done_q, done_d;
  logic                 busy_q, ready_q;
  logic                 timeout_q, timeout_d, overrun_q, overrun_d;
  logic                 tcPulse, lastPix;

  idle_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk_i   (clk_in),
    .rst_i   (rst_in),
    .clear_i (valid_in || (state_q != RECEIVING)),
    .enable_i(state_q == RECEIVING),
    .tc_o    (tcPulse)
  );

  assign lastPix = (xCnt_q == XW'(WIDTH - 1)) && (yCnt_q == YW'(HEIGHT - 1));

  // Rearm clears the sticky flags first so a same-cycle set condition overrides it.
  always_comb begin
    state_d   = state_q;
    xCnt_d    = xCnt_q;
    yCnt_d    = yCnt_q;
    xOut_d    = xOut_q;
    yOut_d    = yOut_q;
    addr_d    = addr_q;
    data_d    = data_q;
    we_d      = 1'b0;
    done_d    = 1'b0;
    timeout_d = timeout_q;
    overrun_d = overrun_q;
    if (rearm_in) begin
      timeout_d = 1'b0;
      overrun_d = 1'b0;
    end
    unique case (state_q)
      IDLE, RECEIVING: begin
        if (state_q == RECEIVING && rearm_in) begin
          state_d = IDLE;
          xCnt_d  = '0;
          yCnt_d  = '0;
          if (tcPulse) timeout_d = 1'b1;
        end else if (valid_in) begin
          we_d   = 1'b1;
          data_d = data_in;
          addr_d = {yCnt_q, xCnt_q};
          xOut_d = xCnt_q;
          yOut_d = yCnt_q;
          if (lastPix) begin
            done_d  = 1'b1;
            state_d = FULL;
            xCnt_d  = '0;
            yCnt_d  = '0;
          end else begin
            state_d = RECEIVING;
            if (xCnt_q == XW'(WIDTH - 1)) begin
              xCnt_d = '0;
              yCnt_d = yCnt_q + YW'(1);
            end else begin
              xCnt_d = xCnt_q + XW'(1);
            end
          end
        end else if (tcPulse) begin
          state_d   = IDLE;
          xCnt_d    = '0;
          yCnt_d    = '0;
          timeout_d = 1'b1;
        end
      end
      FULL: begin
        if (valid_in) overrun_d = 1'b1;
        if (rearm_in) begin
          state_d = IDLE;
          xCnt_d  = '0;
          yCnt_d  = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q   <= IDLE;
      xCnt_q    <= '0;
      yCnt_q    <= '0;
      xOut_q    <= '0;
      yOut_q    <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      we_q      <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      ready_q   <= 1'b0;
      timeout_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      xCnt_q    <= xCnt_d;
      yCnt_q    <= yCnt_d;
      xOut_q    <= xOut_d;
      yOut_q    <= yOut_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      we_q      <= we_d;
      done_q    <= done_d;
      busy_q    <= (state_d == RECEIVING);
      ready_q   <= (state_d == FULL);
      timeout_q <= timeout_d;
      overrun_q <= overrun_d;
    end
  end

  assign addr_out        = addr_q;
  assign data_out        = data_q;
  assign we_out          = we_q;
  assign x_out           = xOut_q;
  assign y_out           = yOut_q;
  assign busy_out        = busy_q;
  assign frame_done_out  = done_q;
  assign image_ready_out = ready_q;
  assign timeout_out     = timeout_q;
  assign overrun_out     = overrun_q;

endmodule

// File: tb/tb_recv_img.sv
// Directed bench for recv_img on a 4x2 frame with a 16-clock timeout, checked against a pixel-index model.
module tb_recv_img;

  localparam int BD = 8;
  localparam int W  = 4;
  localparam int H  = 2;
  localparam int T  = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [BD-1:0] dataIn = '0;
  logic          validIn = 1'b0;
  logic          rearmIn = 1'b0;
  logic [2:0]    addrOut;
  logic [BD-1:0] dataOut;
  logic          weOut;
  logic [1:0]    xOut;
  logic [0:0]    yOut;
  logic          busyOut, doneOut, readyOut, timeoutOut, overrunOut;

  int checks = 0;
  int errors = 0;
  int weCount = 0;
  int doneCount = 0;
  int weBase, doneBase;

  recv_img #(
    .BIT_DEPTH(BD), .WIDTH(W), .HEIGHT(H), .TIMEOUT_CYCLES(T)
  ) dut (
    .clk_in(clk), .rst_in(rst), .data_in(dataIn), .valid_in(validIn),
    .rearm_in(rearmIn), .addr_out(addrOut), .data_out(dataOut), .we_out(weOut),
    .x_out(xOut), .y_out(yOut), .busy_out(busyOut), .frame_done_out(doneOut),
    .image_ready_out(readyOut), .timeout_out(timeoutOut), .overrun_out(overrunOut)
  );

  always #5 clk = ~clk;

  // Model: frame position is a single pixel index; x/y/addr derive from it arithmetically.
  int   mMode = 0;
  int   pixIdx = 0;
  int   idleSeen = 0;
  logic eWe = 0, eDone = 0, eBusy = 0, eReady = 0, eTimeout = 0, eOverrun = 0;
  int   eData = 0, eAddr = 0, eX = 0, eY = 0;

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      mMode = 0; pixIdx = 0; idleSeen = 0;
      eWe = 0; eDone = 0; eTimeout = 0; eOverrun = 0;
      eData = 0; eAddr = 0; eX = 0; eY = 0;
    end else begin
      eWe = 0;
      eDone = 0;
      if (rearmIn) begin
        eTimeout = 0;
        eOverrun = 0;
      end
      if (mMode == 2) begin
        if (validIn) eOverrun = 1;
        if (rearmIn) begin mMode = 0; pixIdx = 0; end
      end else if (mMode == 1 && rearmIn) begin
        if (!validIn && idleSeen + 1 == T) eTimeout = 1;
        mMode = 0; pixIdx = 0;
      end else if (validIn) begin
        eWe = 1; eData = dataIn; eAddr = pixIdx; eX = pixIdx % W; eY = pixIdx / W;
        pixIdx++;
        idleSeen = 0;
        if (pixIdx == W * H) begin
          eDone = 1; mMode = 2; pixIdx = 0;
        end else begin
          mMode = 1;
        end
      end else if (mMode == 1) begin
        idleSeen++;
        if (idleSeen == T) begin
          eTimeout = 1; mMode = 0; pixIdx = 0;
        end
      end
    end
    eBusy  = (mMode == 1);
    eReady = (mMode == 2);
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Every negedge compares the DUT against the model.
  initial forever begin
    @(negedge clk);
    if (weOut === 1'b1) weCount++;
    if (doneOut === 1'b1) doneCount++;
    checkOutput("we", 32'(weOut), 32'(eWe));
    checkOutput("busy", 32'(busyOut), 32'(eBusy));
    checkOutput("ready", 32'(readyOut), 32'(eReady));
    checkOutput("done", 32'(doneOut), 32'(eDone));
    checkOutput("timeout", 32'(timeoutOut), 32'(eTimeout));
    checkOutput("overrun", 32'(overrunOut), 32'(eOverrun));
    if (eWe) begin
      checkOutput("data", 32'(dataOut), eData);
      checkOutput("addr", 32'(addrOut), eAddr);
      checkOutput("x", 32'(xOut), eX);
      checkOutput("y", 32'(yOut), eY);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic applyStimulus(input logic v, input logic [BD-1:0] d, input logic r);
    validIn = v;
    dataIn  = d;
    rearmIn = r;
    step();
    validIn = 1'b0;
    rearmIn = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_we", 32'(weOut), 0);
    checkOutput("rst_busy", 32'(busyOut), 0);
    checkOutput("rst_addr", 32'(addrOut), 0);
    rst = 1'b0;
    step();

    // Full frame, bytes spaced three cycles apart.
    weBase = weCount; doneBase = doneCount;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, BD'(8'h10 + i), 1'b0);
      if (i == 7) begin
        checkOutput("f1_addr", 32'(addrOut), 7);
        checkOutput("f1_x", 32'(xOut), 3);
        checkOutput("f1_y", 32'(yOut), 1);
        checkOutput("f1_data", 32'(dataOut), 32'h17);
        checkOutput("f1_done", 32'(doneOut), 1);
      end
      idle(2);
    end
    checkOutput("f1_ready", 32'(readyOut), 1);
    checkOutput("f1_busy", 32'(busyOut), 0);
    checkOutput("f1_wecount", weCount - weBase, 8);
    checkOutput("f1_donecount", doneCount - doneBase, 1);

    // Overrun while full, then rearm.
    applyStimulus(1'b1, 8'hAA, 1'b0);
    checkOutput("ovr_we", 32'(weOut), 0);
    checkOutput("ovr_flag", 32'(overrunOut), 1);
    applyStimulus(1'b0, 8'h00, 1'b1);
    checkOutput("rearm_ready", 32'(readyOut), 0);
    checkOutput("rearm_ovr", 32'(overrunOut), 0);
    applyStimulus(1'b1, 8'h20, 1'b0);
    checkOutput("rearm_addr0", 32'(addrOut), 0);
    checkOutput("rearm_we", 32'(weOut), 1);

    // Three bytes then a full timeout window.
    applyStimulus(1'b1, 8'h21, 1'b0);
    applyStimulus(1'b1, 8'h22, 1'b0);
    idle(T - 1);
    checkOutput("to_early", 32'(timeoutOut), 0);
    checkOutput("to_early_busy", 32'(busyOut), 1);
    idle(1);
    checkOutput("to_flag", 32'(timeoutOut), 1);
    checkOutput("to_busy", 32'(busyOut), 0);
    doneBase = doneCount;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, BD'(8'h30 + i), 1'b0);
      if (i == 0) checkOutput("f2_addr0", 32'(addrOut), 0);
    end
    checkOutput("f2_addr7", 32'(addrOut), 7);
    checkOutput("f2_done", 32'(doneOut), 1);
    idle(1);
    checkOutput("f2_ready", 32'(readyOut), 1);
    checkOutput("f2_sticky_to", 32'(timeoutOut), 1);
    applyStimulus(1'b0, 8'h00, 1'b1);
    checkOutput("f2_rearm_to", 32'(timeoutOut), 0);

    // Byte lands exactly on the terminal cycle.
    applyStimulus(1'b1, 8'h40, 1'b0);
    applyStimulus(1'b1, 8'h41, 1'b0);
    idle(T - 1);
    applyStimulus(1'b1, 8'h42, 1'b0);
    checkOutput("term_we", 32'(weOut), 1);
    checkOutput("term_addr", 32'(addrOut), 2);
    checkOutput("term_to", 32'(timeoutOut), 0);
    idle(1);
    checkOutput("term_busy", 32'(busyOut), 1);

    // Rearm colliding with a byte mid-frame.
    applyStimulus(1'b0, 8'h00, 1'b1);
    checkOutput("abort_busy", 32'(busyOut), 0);
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, BD'(8'h50 + i), 1'b0);
    applyStimulus(1'b1, 8'h55, 1'b1);
    checkOutput("abort_we", 32'(weOut), 0);
    checkOutput("abort_busy2", 32'(busyOut), 0);
    applyStimulus(1'b1, 8'h60, 1'b0);
    checkOutput("abort_next_addr", 32'(addrOut), 0);

    // Asynchronous reset mid-frame.
    for (int i = 1; i < 4; i++) applyStimulus(1'b1, BD'(8'h60 + i), 1'b0);
    checkOutput("pre_rst_addr", 32'(addrOut), 3);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("arst_we", 32'(weOut), 0);
    checkOutput("arst_busy", 32'(busyOut), 0);
    checkOutput("arst_addr", 32'(addrOut), 0);
    checkOutput("arst_data", 32'(dataOut), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    doneBase = doneCount;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, BD'(8'h70 + i), 1'b0);
      if (i == 0) checkOutput("f3_addr0", 32'(addrOut), 0);
    end
    checkOutput("f3_addr7", 32'(addrOut), 7);
    checkOutput("f3_data", 32'(dataOut), 32'h77);
    idle(2);
    checkOutput("f3_ready", 32'(readyOut), 1);
    checkOutput("f3_donecount", doneCount - doneBase, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/recv_img.md
Name: recv_img

Overview:
- Receive-side counterpart of send_img. Consumes the byte stream from uart_rx and writes it raster-order into a frame BRAM, WIDTH*HEIGHT bytes per frame.
- Generates BRAM write address/enable plus x/y pixel coordinates, so image_half or a BRAM can sit directly downstream.
- Detects frame completion, inter-byte timeout (partial-frame abort) and overrun (bytes arriving while a completed frame is unconsumed).

Parameters:
- BIT_DEPTH, 8, width of each pixel byte and of data_out.
- WIDTH, 64, pixels per row.
- HEIGHT, 64, rows per frame.
- TIMEOUT_CYCLES, 1000000, idle clocks allowed between bytes mid-frame before abort (10 ms at 100 MHz).

Ports:
- clk_in  input  1  system clock (100 MHz).
- rst_in  input  1  asynchronous, active-high reset.
- data_in  input  BIT_DEPTH  byte from uart_rx.
- valid_in  input  1  single-cycle strobe, data_in valid.
- rearm_in  input  1  consumer releases the completed frame; also aborts a frame in progress.
- addr_out  output  $clog2(WIDTH*HEIGHT)  BRAM write address, y*WIDTH+x.
- data_out  output  BIT_DEPTH  pixel to write.
- we_out  output  1  BRAM write enable, one cycle per accepted pixel.
- x_out  output  $clog2(WIDTH)  column of the pixel on data_out.
- y_out  output  $clog2(HEIGHT)  row of the pixel on data_out.
- busy_out  output  1  high in RECEIVING.
- frame_done_out  output  1  one-cycle pulse, last pixel written.
- image_ready_out  output  1  level, high in FULL.
- timeout_out  output  1  sticky, a partial frame was aborted by timeout.
- overrun_out  output  1  sticky, a byte was dropped in FULL.

Behaviour:
- Reset (async assert; deassert sampled on clk_in): state IDLE. All outputs 0. x/y counters, address and timer cleared.
- All outputs are registered. Latency is one cycle: valid_in in cycle N gives we_out, data_out, addr_out, x_out and y_out in cycle N+1.
- States:
  - IDLE: valid_in writes pixel (0,0) and moves to RECEIVING. The timer does not run.
  - RECEIVING: each valid_in writes at the current (x,y). x increments, wrapping at WIDTH-1 to 0 with y+1. The write at (WIDTH-1,HEIGHT-1) goes to FULL, with frame_done_out pulsed in the same cycle as that we_out.
  - FULL: no writes. Each valid_in is dropped and sets overrun_out. rearm_in goes to IDLE with counters cleared.
- Timer: counts clocks in RECEIVING and clears on every accepted byte. On reaching TIMEOUT_CYCLES-1 with no valid_in: go to IDLE, clear counters, set timeout_out. Already-written BRAM contents are not cleaned.
- Simultaneous events:
  - valid_in on the timeout-terminal cycle: the byte wins, it is written and the timer clears.
  - rearm_in with valid_in in RECEIVING: abort wins, the byte is dropped, go to IDLE, no write.
  - rearm_in with valid_in in FULL: go to IDLE, the byte is dropped and overrun_out is set.
  - rearm_in in IDLE: no effect except clearing the sticky flags.
- Sticky flags clear on rst_in or rearm_in. A set condition in the same cycle as rearm_in wins.
- Width rules: addr_out = y*WIDTH + x, computed from the counters before increment and zero-extended. WIDTH and HEIGHT must be powers of two, so the address is the concatenation {y,x}.
- Reset mid-frame: immediate return to IDLE. The next frame restarts at (0,0).

Decomposition:
- recv_img_pkg holds the state enum typedef (IDLE, RECEIVING, FULL) and the localparams PIX_COUNT = WIDTH*HEIGHT and TIMER_W = $clog2(TIMEOUT_CYCLES).
- One sub-module, idle_timer: clear/enable inputs, terminal-count pulse output, parameter TIMEOUT_CYCLES. Reusable by send_img for pacing.

Test Plan (WIDTH=4, HEIGHT=2, TIMEOUT_CYCLES=16):
- Send 8 bytes 0x10..0x17, spaced 3 cycles apart -> we_out x8 at addr 0..7, last at x_out=3, y_out=1. frame_done_out pulses once with the addr 7 write. image_ready_out=1, busy_out=0.
- In FULL, send byte 0xAA -> no we_out, overrun_out=1. Assert rearm_in -> image_ready_out=0, overrun_out=0. Next byte writes addr 0.
- Send 3 bytes, then idle 16 cycles -> timeout_out=1, state IDLE. Then 8 bytes -> writes at addr 0..7, frame completes.
- Assert valid_in exactly on the timer terminal cycle after byte 2 -> the byte is written at addr 2 and timeout_out stays 0.
- Send 5 bytes, then assert rearm_in together with the 6th -> no write for the 6th, next byte writes addr 0.
- Send 4 bytes, assert rst_in asynchronously mid-cycle -> outputs 0 immediately. After release, 8 bytes fill addr 0..7.
